// File: rtl/multi_cycle_control_unit_if.sv
// Control-unit bundle: opcode/flag inputs from the datapath, state-gated strobes and
// decode controls back to it, plus FSM state, halt flag and retired-instruction count.
interface multi_cycle_control_unit_if #(
  parameter int unsigned COUNT_W = 16
);
  logic [5:0]         op;
  logic               zero;
  logic               PCWre;
  logic               InsMemRW;
  logic               IRWre;
  logic               ExtSel;
  logic               RegWre;
  logic               RegOut;
  logic               ALUSrcB;
  logic               ALUM2Reg;
  logic               DataMemRW;
  logic [1:0]         PCSrc;
  logic [2:0]         ALUOp;
  logic [2:0]         state;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport slave (
    input  op, zero,
    output PCWre, InsMemRW, IRWre, ExtSel, RegWre, RegOut, ALUSrcB, ALUM2Reg,
           DataMemRW, PCSrc, ALUOp, state, halted, instr_count
  );

  modport master (
    output op, zero,
    input  PCWre, InsMemRW, IRWre, ExtSel, RegWre, RegOut, ALUSrcB, ALUM2Reg,
           DataMemRW, PCSrc, ALUOp, state, halted, instr_count
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: walks IF/ID/EXE/MEM/WB per instruction, gates PC/IR/RF/DM
// strobes by state, decodes opcode-only controls and counts retired instructions.
module multi_cycle_control_unit #(
  parameter int unsigned COUNT_W = 16,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_cycle_control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic       is_alu_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_halt_s, is_nop_s;
  logic       ext_sel_s, alu_src_b_s, reg_out_s, alu_m2reg_s;
  logic [2:0] alu_op_s;
  logic       pc_wre_s, ins_mem_rw_s, ir_wre_s, reg_wre_s, data_mem_rw_s, halted_s;
  logic [1:0] pc_src_s;

  // Opcode classification and state-independent datapath controls.
  always_comb begin
    is_alu_s    = 1'b0;
    is_lw_s     = 1'b0;
    is_sw_s     = 1'b0;
    is_beq_s    = 1'b0;
    is_j_s      = 1'b0;
    ext_sel_s   = 1'b0;
    alu_src_b_s = 1'b0;
    reg_out_s   = 1'b0;
    alu_m2reg_s = 1'b0;
    alu_op_s    = 3'b000;
    is_halt_s   = (bus.op == HALT_OP);
    case (bus.op)
      OP_ADD:  begin is_alu_s = 1'b1; reg_out_s = 1'b1; alu_op_s = 3'b000; end
      OP_SUB:  begin is_alu_s = 1'b1; reg_out_s = 1'b1; alu_op_s = 3'b001; end
      OP_ADDI: begin is_alu_s = 1'b1; ext_sel_s = 1'b1; alu_src_b_s = 1'b1; alu_op_s = 3'b000; end
      OP_OR:   begin is_alu_s = 1'b1; reg_out_s = 1'b1; alu_op_s = 3'b011; end
      OP_AND:  begin is_alu_s = 1'b1; reg_out_s = 1'b1; alu_op_s = 3'b100; end
      OP_ORI:  begin is_alu_s = 1'b1; alu_src_b_s = 1'b1; alu_op_s = 3'b011; end
      OP_SLT:  begin is_alu_s = 1'b1; reg_out_s = 1'b1; alu_op_s = 3'b110; end
      OP_SW:   begin is_sw_s = 1'b1; ext_sel_s = 1'b1; alu_src_b_s = 1'b1; alu_op_s = 3'b000; end
      OP_LW:   begin
        is_lw_s     = 1'b1;
        ext_sel_s   = 1'b1;
        alu_src_b_s = 1'b1;
        alu_m2reg_s = 1'b1;
        alu_op_s    = 3'b000;
      end
      OP_BEQ:  begin is_beq_s = 1'b1; ext_sel_s = 1'b1; alu_op_s = 3'b001; end
      OP_J:    begin is_j_s = 1'b1; end
      default: begin is_alu_s = 1'b0; end
    endcase
    is_nop_s = ~(is_alu_s | is_lw_s | is_sw_s | is_beq_s | is_j_s | is_halt_s);
  end

  // Next-state and state-gated strobes; PCSrc only departs from 00 alongside PCWre.
  always_comb begin
    state_d       = state_q;
    pc_wre_s      = 1'b0;
    pc_src_s      = 2'b00;
    ins_mem_rw_s  = 1'b0;
    ir_wre_s      = 1'b0;
    reg_wre_s     = 1'b0;
    data_mem_rw_s = 1'b0;
    halted_s      = 1'b0;
    case (state_q)
      S_IF: begin
        ins_mem_rw_s = 1'b1;
        ir_wre_s     = 1'b1;
        state_d      = S_ID;
      end
      S_ID: begin
        if (is_halt_s) begin
          state_d = S_HALT;
        end else if (is_j_s) begin
          pc_wre_s = 1'b1;
          pc_src_s = 2'b10;
          state_d  = S_IF;
        end else if (is_nop_s) begin
          pc_wre_s = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq_s) begin
          pc_wre_s = 1'b1;
          pc_src_s = bus.zero ? 2'b01 : 2'b00;
          state_d  = S_IF;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw_s) begin
          data_mem_rw_s = 1'b1;
          pc_wre_s      = 1'b1;
          state_d       = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_wre_s = 1'b1;
        pc_wre_s  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Retired-instruction counter advances with every PC write and wraps naturally.
  always_comb begin
    if (pc_wre_s) begin
      count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      count_q <= {COUNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.PCWre       = pc_wre_s;
  assign bus.PCSrc       = pc_src_s;
  assign bus.InsMemRW    = ins_mem_rw_s;
  assign bus.IRWre       = ir_wre_s;
  assign bus.RegWre      = reg_wre_s;
  assign bus.DataMemRW   = data_mem_rw_s;
  assign bus.halted      = halted_s;
  assign bus.ExtSel      = ext_sel_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.RegOut      = reg_out_s;
  assign bus.ALUM2Reg    = alu_m2reg_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
